clock_mux_switch_sequencer: RTL

CLOCK_MUX_SWITCH_SEQUENCER -- requirements
Module: clock_mux_switch_sequencer

---
 rtl/clock_mux_switch_sequencer_pkg.sv | 17 +
 rtl/clock_sync_bit.sv | 23 ++
 rtl/clock_mux_switch_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/clock_mux_switch_sequencer_pkg.sv
// Shared types and default constants for the glitch-free clock mux switch sequencer.
package clock_mux_switch_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    DROP_OLD      = 3'd1,
    WAIT_OLD_LOW  = 3'd2,
    RAISE_NEW     = 3'd3,
    WAIT_NEW_HIGH = 3'd4,
    DONE          = 3'd5,
    ERROR         = 3'd6
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_SYNC_STAGES    = 2;

endpackage

// File: rtl/clock_sync_bit.sv
// Multi-flop synchronizer bringing one asynchronous level into the clk domain.
module clock_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clock_mux_switch_sequencer.sv
// Sequences a break-before-make switch of a two-input glitch-free clock mux,
// with per-wait timeouts and a sticky error that is cleared explicitly.
module clock_mux_switch_sequencer
  import clock_mux_switch_sequencer_pkg::*;
#(
  parameter bit RESET_SEL      = 1'b0,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic async_enable0,
  output logic async_enable1,
  input  logic async_enable0_ack,
  input  logic async_enable1_ack,
  output logic cur_sel,
  output logic done,
  output logic error,
  input  logic error_clear
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [1:0]       EN_RESET    = RESET_SEL ? 2'b10 : 2'b01;

  state_e           state_q, state_d;
  logic [1:0]       en_q, en_d;
  logic             cur_sel_q, cur_sel_d;
  logic             target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             done_q, error_q, req_ready_q;
  logic             ack0_s, ack1_s, old_ack, new_ack;

  clock_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack0 (
    .clk_i  (clock),
    .srst_i (reset),
    .d_i    (async_enable0_ack),
    .q_o    (ack0_s)
  );

  clock_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack1 (
    .clk_i  (clock),
    .srst_i (reset),
    .d_i    (async_enable1_ack),
    .q_o    (ack1_s)
  );

  assign old_ack = cur_sel_q ? ack1_s : ack0_s;
  assign new_ack = target_q  ? ack1_s : ack0_s;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    cur_sel_d = cur_sel_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_sel == cur_sel_q) begin
            state_d = DONE;
          end else begin
            // Old enable drops on the accepting edge so it is seen in DROP_OLD.
            target_d         = req_sel;
            en_d[cur_sel_q]  = 1'b0;
            state_d          = DROP_OLD;
          end
        end
      end
      DROP_OLD: begin
        cnt_d   = '0;
        state_d = WAIT_OLD_LOW;
      end
      WAIT_OLD_LOW: begin
        // An ack seen on the final counted cycle takes priority over the timeout.
        if (!old_ack) begin
          en_d[target_q] = 1'b1;
          state_d        = RAISE_NEW;
        end else if (cnt_inc == TIMEOUT_VAL) begin
          en_d    = 2'b00;
          state_d = ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RAISE_NEW: begin
        cnt_d   = '0;
        state_d = WAIT_NEW_HIGH;
      end
      WAIT_NEW_HIGH: begin
        if (new_ack) begin
          cur_sel_d = target_q;
          state_d   = DONE;
        end else if (cnt_inc == TIMEOUT_VAL) begin
          en_d    = 2'b00;
          state_d = ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERROR: begin
        en_d = 2'b00;
        if (error_clear) begin
          en_d[cur_sel_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      en_q        <= EN_RESET;
      cur_sel_q   <= RESET_SEL;
      target_q    <= RESET_SEL;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      cur_sel_q   <= cur_sel_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      done_q      <= (state_q == DONE);
      error_q     <= (state_d == ERROR);
      req_ready_q <= (state_d == IDLE);
    end
  end

  assign req_ready     = req_ready_q;
  assign async_enable0 = en_q[0];
  assign async_enable1 = en_q[1];
  assign cur_sel       = cur_sel_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule
